// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO management-device slice:
// FSM states, opcodes, field widths and fixed frame positions.
package mdio_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ST,
    S_OP,
    S_ADDR,
    S_TAW,
    S_WDATA,
    S_TA2,
    S_RDATA,
    S_SKIP
  } mdio_state_e;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  localparam int PHYAD_W   = 5;
  localparam int REGAD_W   = 5;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 32;
  localparam int ADDR_W    = PHYAD_W + REGAD_W;

  // Bit positions inside the 32-bit frame (bit 0 is the first ST bit).
  localparam logic [4:0] POS_OP_LAST   = 5'd3;
  localparam logic [4:0] POS_ADDR_LAST = 5'd13;
  localparam logic [4:0] POS_TA_FIRST  = 5'd14;
  localparam logic [4:0] POS_TA_LAST   = 5'd15;
  localparam logic [4:0] POS_LAST      = 5'(FRAME_LEN - 1);

endpackage

// File: rtl/mdc_edge_det.sv
// Turns the oversampled management clock into single-clk rise/fall pulses.
module mdc_edge_det (
  input  logic clk,
  input  logic mdc,
  output logic rise,
  output logic fall
);

  logic mdc_q;

  // Tracks mdc even during reset so no phantom edge appears on release.
  always_ff @(posedge clk) begin
    mdc_q <= mdc;
  end

  assign rise = mdc & ~mdc_q;
  assign fall = ~mdc & mdc_q;

endmodule

// File: rtl/mdio_peripheral.sv
// PHY-side Clause-22 MDIO frame decoder with a simple register-file port;
// samples on mdc rise, drives mdio_in on mdc fall during read data.
module mdio_peripheral
  import mdio_pkg::*;
#(
  parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'd31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mdc,
  input  logic               mdio_oe,
  input  logic               mdio_out,
  output logic               mdio_in,
  output logic [REGAD_W-1:0] reg_addr,
  output logic [DATA_W-1:0]  reg_wdata,
  output logic               reg_we,
  output logic               reg_rd,
  input  logic [DATA_W-1:0]  reg_rdata
);

  logic rise, fall;

  mdio_state_e        state, state_n;
  logic [4:0]         bit_cnt, cnt_n;
  logic [1:0]         op_q, op_n;
  logic [ADDR_W-1:0]  addr_sr, addr_n, addr_full;
  logic [DATA_W-1:0]  data_sr, data_n, data_full;
  logic [DATA_W-1:0]  tx_sr, tx_n;
  logic               rd_pend;
  logic               mdio_in_n;
  logic [REGAD_W-1:0] reg_addr_n;
  logic [DATA_W-1:0]  reg_wdata_n;
  logic               we_n, rd_n;

  mdc_edge_det u_edge (
    .clk  (clk),
    .mdc  (mdc),
    .rise (rise),
    .fall (fall)
  );

  assign addr_full = {addr_sr[ADDR_W-2:0], mdio_out};
  assign data_full = {data_sr[DATA_W-2:0], mdio_out};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      op_q      <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      tx_sr     <= '0;
      rd_pend   <= 1'b0;
      mdio_in   <= 1'b1;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_rd    <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= cnt_n;
      op_q      <= op_n;
      addr_sr   <= addr_n;
      data_sr   <= data_n;
      tx_sr     <= tx_n;
      rd_pend   <= reg_rd;
      mdio_in   <= mdio_in_n;
      reg_addr  <= reg_addr_n;
      reg_wdata <= reg_wdata_n;
      reg_we    <= we_n;
      reg_rd    <= rd_n;
    end
  end

  // Read data arrives one clk after reg_rd, so capture it on the cycle after.
  always_comb begin
    state_n     = state;
    cnt_n       = bit_cnt;
    op_n        = op_q;
    addr_n      = addr_sr;
    data_n      = data_sr;
    tx_n        = rd_pend ? reg_rdata : tx_sr;
    mdio_in_n   = mdio_in;
    reg_addr_n  = reg_addr;
    reg_wdata_n = reg_wdata;
    we_n        = 1'b0;
    rd_n        = 1'b0;

    case (state)
      S_IDLE: begin
        if (rise && mdio_oe && !mdio_out) begin
          state_n = S_ST;
          cnt_n   = 5'd1;
        end
      end
      S_ST: begin
        if (rise && mdio_oe && mdio_out) begin
          state_n = S_OP;
          cnt_n   = 5'd2;
        end
      end
      S_OP: begin
        if (rise) begin
          if (!mdio_oe) begin
            state_n = S_IDLE;
          end else begin
            cnt_n = bit_cnt + 5'd1;
            op_n  = {op_q[0], mdio_out};
            if (bit_cnt == POS_OP_LAST)
              state_n = ({op_q[0], mdio_out} inside {OP_WRITE, OP_READ}) ? S_ADDR : S_SKIP;
          end
        end
      end
      S_ADDR: begin
        if (rise) begin
          if (!mdio_oe) begin
            state_n = S_IDLE;
          end else begin
            cnt_n  = bit_cnt + 5'd1;
            addr_n = addr_full;
            if (bit_cnt == POS_ADDR_LAST) begin
              if (addr_full[ADDR_W-1:REGAD_W] != PHY_ADDR) begin
                state_n = S_SKIP;
              end else if (op_q == OP_READ) begin
                rd_n       = 1'b1;
                reg_addr_n = addr_full[REGAD_W-1:0];
                state_n    = S_TA2;
              end else begin
                state_n = S_TAW;
              end
            end
          end
        end
      end
      S_TAW: begin
        if (rise) begin
          if (!mdio_oe) begin
            state_n = S_IDLE;
          end else begin
            cnt_n = bit_cnt + 5'd1;
            if (mdio_out != (bit_cnt == POS_TA_FIRST))
              state_n = S_SKIP;
            else if (bit_cnt == POS_TA_LAST)
              state_n = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (rise) begin
          if (!mdio_oe) begin
            state_n = S_IDLE;
          end else begin
            cnt_n  = bit_cnt + 5'd1;
            data_n = data_full;
            if (bit_cnt == POS_LAST) begin
              we_n        = 1'b1;
              reg_wdata_n = data_full;
              reg_addr_n  = addr_sr[REGAD_W-1:0];
              state_n     = S_IDLE;
            end
          end
        end
      end
      S_TA2: begin
        if (rise) begin
          if (mdio_oe) begin
            mdio_in_n = 1'b1;
            state_n   = S_IDLE;
          end else begin
            cnt_n = bit_cnt + 5'd1;
          end
        end else if (fall && bit_cnt == POS_TA_LAST) begin
          mdio_in_n = 1'b0;
          state_n   = S_RDATA;
        end
      end
      // The counter wraps to 0 on the last data rise, marking the release fall.
      S_RDATA: begin
        if (rise) begin
          if (mdio_oe) begin
            mdio_in_n = 1'b1;
            state_n   = S_IDLE;
          end else begin
            cnt_n = bit_cnt + 5'd1;
          end
        end else if (fall) begin
          if (bit_cnt == 5'd0) begin
            mdio_in_n = 1'b1;
            state_n   = S_IDLE;
          end else begin
            mdio_in_n = tx_sr[DATA_W-1];
            tx_n      = {tx_sr[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_SKIP: begin
        if (rise) begin
          cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == POS_LAST)
            state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
